// File: rtl/pulse_measure.sv
// pulse_measure: measures the high time, low time and period of an
// asynchronous pulse train. Each result covers one complete high+low period.
//
// Parameters:
//   TIMEOUT      phase length in cycles at which the input is declared stalled
//   SYNC_STAGES  synchronizer depth on pulse_in (minimum 2)
//
// Ports:
//   clk         clock, rising edge
//   reset       synchronous, active-high
//   pulse_in    asynchronous pulse train to measure
//   meas_ack    consumer accepts the current result
//   meas_valid  high_len/low_len/period_len hold an unconsumed result
//   high_len    cycles high in the last complete period
//   low_len     cycles low in the last complete period
//   period_len  high_len + low_len, saturating
//   overrun     sticky: a result was overwritten before acknowledgement
//   stalled     no edge seen for TIMEOUT cycles
//
// state | meaning
// IDLE  | waiting for a fall; any current phase is partial and discarded
// ARM   | low phase in progress, waiting for the rise that opens a period
// HIGH  | timing the high phase
// LOW   | timing the low phase; the closing rise publishes a result
module pulse_measure #(
  parameter logic [31:0] TIMEOUT     = 32'd50_000_000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pulse_in,
  input  logic        meas_ack,
  output logic        meas_valid,
  output logic [31:0] high_len,
  output logic [31:0] low_len,
  output logic [31:0] period_len,
  output logic        overrun,
  output logic        stalled
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] LOW  = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic [31:0]            cnt;
  logic [31:0]            high_hold;
  logic [1:0]             state;

  logic        s;
  logic        rise;
  logic        fall;
  logic        edge_seen;
  logic        timeout;
  logic        load;
  logic [32:0] sum;
  logic [31:0] sum_sat;

  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~s_d;
  assign fall      = ~s & s_d;
  assign edge_seen = rise | fall;
  // An edge reloads cnt, so a timeout can only be taken on an edge-free cycle.
  assign timeout   = ~edge_seen & (cnt == TIMEOUT);
  assign load      = (state == LOW) & rise;
  assign sum       = {1'b0, high_hold} + {1'b0, cnt};
  assign sum_sat   = sum[32] ? 32'hFFFF_FFFF : sum[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      s_d    <= s;
    end
  end

  // cnt equals the number of synchronized cycles spent in the current phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 32'd0;
    end else if (edge_seen) begin
      cnt <= 32'd1;
    end else if (cnt != 32'hFFFF_FFFF) begin
      cnt <= cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      high_hold <= 32'd0;
    end else if (timeout) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (fall) state <= ARM;
        ARM:  if (rise) state <= HIGH;
        HIGH: begin
          if (fall) begin
            high_hold <= cnt;
            state     <= LOW;
          end
        end
        default: if (rise) state <= HIGH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      high_len   <= 32'd0;
      low_len    <= 32'd0;
      period_len <= 32'd0;
    end else if (load) begin
      high_len   <= high_hold;
      low_len    <= cnt;
      period_len <= sum_sat;
    end
  end

  // An ack in the same cycle as a new load consumes the old result, so the
  // overwrite is not an overrun and the new result stays valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      meas_valid <= 1'b1;
      if (meas_valid & ~meas_ack) begin
        overrun <= 1'b1;
      end else if (meas_ack) begin
        overrun <= 1'b0;
      end
    end else if (meas_ack & meas_valid) begin
      meas_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stalled <= 1'b0;
    end else if (edge_seen) begin
      stalled <= 1'b0;
    end else if (timeout) begin
      stalled <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_measure.sv
// Testbench for pulse_measure: table-driven periods plus hand-written
// sequences for latency, ack/load collision, timeout and mid-phase reset.
module tb_pulse_measure;

  logic        clk = 1'b0;
  logic        reset;
  logic        pulse_in;
  logic        meas_ack;
  logic        meas_valid;
  logic [31:0] high_len;
  logic [31:0] low_len;
  logic [31:0] period_len;
  logic        overrun;
  logic        stalled;

  int total = 0;
  int bad   = 0;

  pulse_measure #(.TIMEOUT(32'd100), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .pulse_in   (pulse_in),
    .meas_ack   (meas_ack),
    .meas_valid (meas_valid),
    .high_len   (high_len),
    .low_len    (low_len),
    .period_len (period_len),
    .overrun    (overrun),
    .stalled    (stalled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          h;
    int          l;
    bit          ack;
    logic [31:0] eh;
    logic [31:0] el;
    logic [31:0] ep;
    bit          ev;
    bit          eo;
  } vec_t;

  vec_t vecs[4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic lvl, input int n);
    pulse_in = lvl;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [31:0] eh, input logic [31:0] el,
                         input logic [31:0] ep, input bit ev, input bit eo);
    chk({name, ".high_len"},   high_len,   eh);
    chk({name, ".low_len"},    low_len,    el);
    chk({name, ".period_len"}, period_len, ep);
    chk({name, ".meas_valid"}, {31'd0, meas_valid}, {31'd0, ev});
    chk({name, ".overrun"},    {31'd0, overrun},    {31'd0, eo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{h: 3, l: 7, ack: 1'b0, eh: 32'd5, el: 32'd10, ep: 32'd15, ev: 1'b1, eo: 1'b0};
    vecs[1] = '{h: 4, l: 8, ack: 1'b0, eh: 32'd3, el: 32'd7,  ep: 32'd10, ev: 1'b1, eo: 1'b1};
    vecs[2] = '{h: 2, l: 2, ack: 1'b1, eh: 32'd4, el: 32'd8,  ep: 32'd12, ev: 1'b1, eo: 1'b1};
    vecs[3] = '{h: 2, l: 2, ack: 1'b0, eh: 32'd2, el: 32'd2,  ep: 32'd4,  ev: 1'b1, eo: 1'b0};

    reset    = 1'b1;
    pulse_in = 1'b0;
    meas_ack = 1'b0;
    step();
    step();
    chk_out("reset", 0, 0, 0, 1'b0, 1'b0);
    chk("reset.stalled", {31'd0, stalled}, 32'd0);
    reset = 1'b0;

    // First full period 5/10 after reset, with latency check.
    drive(1'b1, 5);
    drive(1'b0, 10);
    drive(1'b1, 5);
    drive(1'b0, 10);
    chk("no_result_before_period", {31'd0, meas_valid}, 32'd0);
    pulse_in = 1'b1;
    step();
    step();
    chk("latency_early", {31'd0, meas_valid}, 32'd0);
    step();
    chk_out("first_result", 5, 10, 15, 1'b1, 1'b0);
    meas_ack = 1'b1;
    step();
    meas_ack = 1'b0;
    chk("ack_clear.valid", {31'd0, meas_valid}, 32'd0);
    step();
    drive(1'b0, 10);

    // Each entry checks the previous period's result one cycle before the
    // end of its own low phase; the optional ack is that final low cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i].h);
      drive(1'b0, vecs[i].l - 1);
      chk_out($sformatf("vec%0d", i), vecs[i].eh, vecs[i].el, vecs[i].ep, vecs[i].ev, vecs[i].eo);
      meas_ack = vecs[i].ack;
      step();
      meas_ack = 1'b0;
      if (vecs[i].ack) begin
        chk($sformatf("vec%0d.ack_valid", i),   {31'd0, meas_valid}, 32'd0);
        chk($sformatf("vec%0d.ack_overrun", i), {31'd0, overrun},    32'd0);
      end
    end

    // Ack in the very cycle a new 2/2 result loads.
    pulse_in = 1'b1;
    step();
    step();
    meas_ack = 1'b1;
    step();
    meas_ack = 1'b0;
    chk_out("ack_on_load", 2, 2, 4, 1'b1, 1'b0);
    step();
    chk("ack_on_load.held", {31'd0, meas_valid}, 32'd1);
    step();
    drive(1'b0, 5);

    // 1 high / 1 low alternation.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
      if (i >= 4) begin
        chk($sformatf("toggle%0d.high", i),   high_len,   32'd1);
        chk($sformatf("toggle%0d.low", i),    low_len,    32'd1);
        chk($sformatf("toggle%0d.period", i), period_len, 32'd2);
      end
    end

    // Hold high: cnt reaches 100 after 102 steps, stalled one step later.
    pulse_in = 1'b1;
    for (int i = 0; i < 102; i++) step();
    chk("stall.before", {31'd0, stalled}, 32'd0);
    step();
    chk("stall.set", {31'd0, stalled}, 32'd1);
    chk_out("stall.retained", 1, 1, 2, 1'b1, 1'b1);
    pulse_in = 1'b0;
    step();
    step();
    chk("stall.hold", {31'd0, stalled}, 32'd1);
    step();
    chk("stall.clear", {31'd0, stalled}, 32'd0);
    drive(1'b0, 7);
    drive(1'b1, 3);
    chk_out("stall.no_partial", 1, 1, 2, 1'b1, 1'b1);
    drive(1'b1, 1);
    drive(1'b0, 6);
    pulse_in = 1'b1;
    step();
    step();
    chk("stall.next_early", high_len, 32'd1);
    step();
    chk_out("stall.next_result", 4, 6, 10, 1'b1, 1'b1);

    // Reset in the middle of a high phase.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_out("midreset", 0, 0, 0, 1'b0, 1'b0);
    chk("midreset.stalled", {31'd0, stalled}, 32'd0);
    drive(1'b1, 2);
    drive(1'b0, 5);
    drive(1'b1, 5);
    drive(1'b0, 5);
    chk("midreset.no_result", {31'd0, meas_valid}, 32'd0);
    pulse_in = 1'b1;
    step();
    step();
    step();
    chk_out("midreset.result", 5, 5, 10, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
